// File: rtl/cnn_buf_pkg.sv
// Shared constants and types for the CNN feature-map buffers.
// FMAP_DW / FMAP_DEPTH / FMAP_AW : default word width, words per bank, address width.
// drn_state_t                    : drain FSM state encoding.
package cnn_buf_pkg;
    localparam int unsigned FMAP_DW    = 9;
    localparam int unsigned FMAP_DEPTH = 14;
    localparam int unsigned FMAP_AW    = 4;

    typedef enum logic {
        DRN_IDLE = 1'b0,
        DRN_RUN  = 1'b1
    } drn_state_t;
endpackage

// File: rtl/fmap_bank.sv
// Single feature-map bank: register array with one write port, one-cycle bulk clear,
// one registered read port and one combinational index port.
// i_clk, i_reset           : clock, synchronous active-high reset (clears array and read reg)
// i_wr_en/addr/data, i_clr : write port; i_clr zeroes every word and overrides i_wr_en
// i_rd_en/addr, o_rd_data  : registered read, holds when i_rd_en=0, 0 when out of range
// i_idx, o_idx_data        : combinational read, 0 when out of range
module fmap_bank
    import cnn_buf_pkg::*;
#(
    parameter int unsigned DW    = FMAP_DW,
    parameter int unsigned DEPTH = FMAP_DEPTH,
    parameter int unsigned AW    = FMAP_AW
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic signed [DW-1:0] i_wr_data,
    input  logic                 i_clr,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_addr,
    output logic signed [DW-1:0] o_rd_data,
    input  logic [AW-1:0]        i_idx,
    output logic signed [DW-1:0] o_idx_data
);
    localparam logic [AW:0] LIM = (AW + 1)'(DEPTH);

    logic signed [DW-1:0] r_mem [DEPTH];
    logic signed [DW-1:0] r_rd_data;
    logic                 w_wr_ok;
    logic                 w_rd_ok;
    logic                 w_idx_ok;

    assign w_wr_ok  = ({1'b0, i_wr_addr} < LIM);
    assign w_rd_ok  = ({1'b0, i_rd_addr} < LIM);
    assign w_idx_ok = ({1'b0, i_idx} < LIM);

    // Read samples the array before this edge's write lands: read-before-write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            r_rd_data <= '0;
        end else begin
            if (i_rd_en) r_rd_data <= w_rd_ok ? r_mem[i_rd_addr] : '0;
            if (i_clr) begin
                for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
            end else if (i_wr_en && w_wr_ok) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_idx_data = w_idx_ok ? r_mem[i_idx] : '0;
endmodule

// File: rtl/fmap_pingpong_buf.sv
// Double-banked signed feature-map buffer. The compute side writes/reads the write bank
// (index o_wbank); the readout side streams the other bank with a ready/valid drain.
// i_clk, i_reset                    : clock, synchronous active-high reset
// i_wr_en/addr/data, i_wr_clr       : write port and bulk clear of the write bank
// o_wr_err                          : one-cycle pulse after an out-of-range write
// i_rd_en/addr, o_rd_data/o_rd_valid: latency-1 read of the write bank
// i_swap, o_swap_pend, o_wbank      : bank exchange, deferred while a drain runs
// i_drain_start, o_drain_busy       : start / running indication of the drain stream
// o_drain_valid/data/last, i_drain_ready : stream handshake, last on index DEPTH-1
module fmap_pingpong_buf
    import cnn_buf_pkg::*;
#(
    parameter int unsigned DW    = FMAP_DW,
    parameter int unsigned DEPTH = FMAP_DEPTH,
    parameter int unsigned AW    = FMAP_AW
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic signed [DW-1:0] i_wr_data,
    input  logic                 i_wr_clr,
    output logic                 o_wr_err,
    input  logic                 i_rd_en,
    input  logic [AW-1:0]        i_rd_addr,
    output logic signed [DW-1:0] o_rd_data,
    output logic                 o_rd_valid,
    input  logic                 i_swap,
    output logic                 o_swap_pend,
    output logic                 o_wbank,
    input  logic                 i_drain_start,
    output logic                 o_drain_busy,
    output logic                 o_drain_valid,
    input  logic                 i_drain_ready,
    output logic signed [DW-1:0] o_drain_data,
    output logic                 o_drain_last
);
    localparam logic [AW:0]   LIM      = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    drn_state_t           r_state;
    logic [AW-1:0]        r_idx;
    logic                 r_wbank;
    logic                 r_pend;
    logic                 r_rd_sel;
    logic                 r_rd_valid;
    logic                 r_wr_err;
    logic signed [DW-1:0] w_rd_data  [2];
    logic signed [DW-1:0] w_idx_data [2];
    logic                 w_fire;
    logic                 w_last_fire;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        logic w_sel;
        assign w_sel = (r_wbank == 1'(g));

        fmap_bank #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_bank (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_wr_en    (i_wr_en && w_sel),
            .i_wr_addr  (i_wr_addr),
            .i_wr_data  (i_wr_data),
            .i_clr      (i_wr_clr && w_sel),
            .i_rd_en    (i_rd_en && w_sel),
            .i_rd_addr  (i_rd_addr),
            .o_rd_data  (w_rd_data[g]),
            .i_idx      (r_idx),
            .o_idx_data (w_idx_data[g])
        );
    end

    assign w_fire      = (r_state == DRN_RUN) && i_drain_ready;
    assign w_last_fire = w_fire && (r_idx == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= DRN_IDLE;
            r_idx      <= '0;
            r_wbank    <= 1'b0;
            r_pend     <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_sel <= r_wbank;
            r_wr_err <= i_wr_en && !i_wr_clr && !({1'b0, i_wr_addr} < LIM);

            // A swap colliding with an active or just-starting drain waits for the last beat.
            if (w_last_fire && (r_pend || i_swap)) begin
                r_wbank <= ~r_wbank;
                r_pend  <= 1'b0;
            end else if (i_swap) begin
                if (r_state == DRN_RUN || i_drain_start) r_pend <= 1'b1;
                else                                     r_wbank <= ~r_wbank;
            end

            case (r_state)
                DRN_IDLE: begin
                    if (i_drain_start) begin
                        r_state <= DRN_RUN;
                        r_idx   <= '0;
                    end
                end
                DRN_RUN: begin
                    if (w_last_fire) begin
                        r_state <= DRN_IDLE;
                        r_idx   <= '0;
                    end else if (w_fire) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: r_state <= DRN_IDLE;
            endcase
        end
    end

    // Outputs decode directly from registers, so they are stable during a stall.
    assign o_rd_data     = w_rd_data[r_rd_sel];
    assign o_rd_valid    = r_rd_valid;
    assign o_wr_err      = r_wr_err;
    assign o_swap_pend   = r_pend;
    assign o_wbank       = r_wbank;
    assign o_drain_busy  = (r_state == DRN_RUN);
    assign o_drain_valid = (r_state == DRN_RUN);
    assign o_drain_last  = (r_state == DRN_RUN) && (r_idx == LAST_IDX);
    assign o_drain_data  = (r_state == DRN_RUN) ? w_idx_data[~r_wbank] : '0;
endmodule
